// File: rtl/dram_timing_ctrl_if.sv
// Bus bundle between the Z80 side and the DRAM timing controller.
// master drives strobes/selects; slave drives the DRAM strobes back.
interface dram_timing_ctrl_if #(
  parameter int BANKS = 2
);
  logic             nmreq;
  logic             nrfshd;
  logic [BANKS-1:0] nsltsl;
  logic [BANKS-1:0] nras;
  logic             mux;
  logic             ncas;
  logic             nwait;
  logic             busy;

  modport master (
    output nmreq,
    output nrfshd,
    output nsltsl,
    input  nras,
    input  mux,
    input  ncas,
    input  nwait,
    input  busy
  );

  modport slave (
    input  nmreq,
    input  nrfshd,
    input  nsltsl,
    output nras,
    output mux,
    output ncas,
    output nwait,
    output busy
  );
endinterface

// File: rtl/dram_timing_ctrl.sv
// RAS -> MUX -> CAS sequencer with RAS-only refresh and precharge.
// Optional Z80 wait generation is enabled by defining DRAM_WAIT_EN.
module dram_timing_ctrl #(
  parameter int BANKS     = 2,
  parameter int MUX_DELAY = 1,
  parameter int CAS_DELAY = 1,
  parameter int PRECHARGE = 2
) (
  input logic          clk,
  input logic          nreset,
  dram_timing_ctrl_if.slave bus
);

  localparam int MD = (MUX_DELAY > CAS_DELAY)
                    ? MUX_DELAY : CAS_DELAY;
  localparam int MAXD = (MD > PRECHARGE)
                      ? MD : PRECHARGE;
  localparam int CW = $clog2(MAXD + 1);

  localparam logic [CW-1:0] LD_MUX = CW'(MUX_DELAY);
  localparam logic [CW-1:0] LD_CAS = CW'(CAS_DELAY);
  localparam logic [CW-1:0] LD_PRE = CW'(PRECHARGE);
  localparam logic [CW-1:0] ONE    = CW'(1);

`ifdef DRAM_WAIT_EN
  localparam logic WAIT_ON = 1'b1;
`else
  localparam logic WAIT_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_RFSH,
    S_RAS,
    S_MUXD,
    S_CAS,
    S_PRE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [BANKS-1:0] nras_q;
  logic             mux_q;
  logic             ncas_q;
  logic             nwait_q;
  logic             busy_q;

  logic [BANKS-1:0] sel_oh;
  logic             sel_any;
  logic             req;
  logic             rfsh_req;
  logic             acc_req;
  logic             cnt_end;
  logic             active;

  // Lowest-index active select wins.
  always_comb begin
    sel_oh  = '0;
    sel_any = 1'b0;
    for (int i = BANKS - 1; i >= 0; i--) begin
      if (!bus.nsltsl[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_any   = 1'b1;
      end
    end
  end

  assign req      = !bus.nmreq;
  assign rfsh_req = req && !bus.nrfshd;
  assign acc_req  = req && bus.nrfshd && sel_any;
  assign cnt_end  = (cnt_q == ONE);
  assign active   = (state_q == S_RFSH) ||
                    (state_q == S_RAS)  ||
                    (state_q == S_MUXD) ||
                    (state_q == S_CAS);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      nras_q  <= '1;
      mux_q   <= 1'b0;
      ncas_q  <= 1'b1;
      nwait_q <= 1'b1;
      busy_q  <= 1'b0;
    end else if (active && !req) begin
      // Normal end and early abort share one release path.
      state_q <= S_PRE;
      cnt_q   <= LD_PRE;
      nras_q  <= '1;
      mux_q   <= 1'b0;
      ncas_q  <= 1'b1;
      nwait_q <= 1'b1;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (rfsh_req) begin
            state_q <= S_RFSH;
            nras_q  <= '0;
            busy_q  <= 1'b1;
            nwait_q <= 1'b1;
          end else if (acc_req) begin
            state_q <= S_RAS;
            cnt_q   <= LD_MUX;
            nras_q  <= ~sel_oh;
            busy_q  <= 1'b1;
            nwait_q <= !WAIT_ON;
          end else begin
            nwait_q <= 1'b1;
          end
        end
        S_RFSH: begin
          state_q <= S_RFSH;
        end
        S_RAS: begin
          if (cnt_end) begin
            state_q <= S_MUXD;
            cnt_q   <= LD_CAS;
            mux_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        S_MUXD: begin
          if (cnt_end) begin
            state_q <= S_CAS;
            ncas_q  <= 1'b0;
            nwait_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        S_CAS: begin
          state_q <= S_CAS;
        end
        S_PRE: begin
          nwait_q <= !(WAIT_ON && acc_req);
          if (cnt_end) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          nras_q  <= '1;
          mux_q   <= 1'b0;
          ncas_q  <= 1'b1;
          nwait_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.nras  = nras_q;
  assign bus.mux   = mux_q;
  assign bus.ncas  = ncas_q;
  assign bus.nwait = nwait_q;
  assign bus.busy  = busy_q;

endmodule
